// File: rtl/sonar_ping_seq_pkg.sv
// Shared definitions for the sonar ping sequencer: state encodings and the
// default width of configuration, counter and time-of-flight fields.
package sonar_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TX     = 3'd1,
      ST_BLANK  = 3'd2,
      ST_LISTEN = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/sonar_ping_seq_if.sv
// Control, configuration and status bundle between the ping sequencer and its
// host; the master side drives requests/config, the slave side is the sequencer.
interface sonar_ping_seq_if
   import sonar_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) ();

   logic             start;
   logic             abort;
   logic             ce_pcm;
   logic [CNT_W-1:0] tx_pulses;
   logic [CNT_W-1:0] tx_half;
   logic [CNT_W-1:0] blank_len;
   logic [CNT_W-1:0] listen_len;
   logic             cmp;
   logic             tx_out;
   logic             mclear;
   logic             busy;
   logic             done;
   logic             hit;
   logic [CNT_W-1:0] tof;
   logic [2:0]       state;

   modport master (
      output start, abort, ce_pcm, tx_pulses, tx_half, blank_len, listen_len, cmp,
      input  tx_out, mclear, busy, done, hit, tof, state
   );

   modport slave (
      input  start, abort, ce_pcm, tx_pulses, tx_half, blank_len, listen_len, cmp,
      output tx_out, mclear, busy, done, hit, tof, state
   );

endinterface

// File: rtl/sonar_ping_seq_tx_gen.sv
// Transducer burst generator: tx_out rises on the first enabled edge and
// toggles every tx_half cycles; last flags the final cycle of the burst.
module sonar_tx_gen
   import sonar_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] tx_pulses,
   input  logic [CNT_W-1:0] tx_half,
   output logic             tx_out,
   output logic             last
);

   logic             active_q, active_d;
   logic             tx_q, tx_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W:0]   tcnt_q, tcnt_d;
   logic [CNT_W-1:0] half_end;
   logic [CNT_W:0]   burst_end;
   logic             period_end;

   // A zero half-period is treated as a one-cycle half-period.
   function automatic logic [CNT_W-1:0] half_eff(input logic [CNT_W-1:0] h);
      return (h == '0) ? CNT_W'(1) : h;
   endfunction

   always_comb begin
      half_end   = half_eff(tx_half) - CNT_W'(1);
      burst_end  = {tx_pulses, 1'b0} - (CNT_W+1)'(1);
      period_end = (hcnt_q == half_end);
      last       = active_q && period_end && (tcnt_q == burst_end);

      active_d = enable;
      tx_d     = tx_q;
      hcnt_d   = hcnt_q;
      tcnt_d   = tcnt_q;
      if (!enable) begin
         tx_d   = 1'b0;
         hcnt_d = '0;
         tcnt_d = '0;
      end else if (!active_q) begin
         tx_d   = 1'b1;
         hcnt_d = '0;
         tcnt_d = '0;
      end else if (period_end) begin
         tx_d   = ~tx_q;
         hcnt_d = '0;
         tcnt_d = tcnt_q + (CNT_W+1)'(1);
      end else begin
         hcnt_d = hcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         tx_q     <= 1'b0;
         hcnt_q   <= '0;
         tcnt_q   <= '0;
      end else begin
         active_q <= active_d;
         tx_q     <= tx_d;
         hcnt_q   <= hcnt_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign tx_out = tx_q;

endmodule

// File: rtl/sonar_ping_seq.sv
// Sonar ping sequencer: transmit burst, blanking, listen window with echo
// detection and time-of-flight capture, then a one-cycle done pulse.
module sonar_ping_seq
   import sonar_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   sonar_ping_seq_if.slave bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] pulses_q, pulses_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] blank_q, blank_d;
   logic [CNT_W-1:0] listen_q, listen_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tof_q, tof_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             hit_q, hit_d;
   logic             mclear_q, done_q, busy_q;
   logic             tx_en, tx_last, tx_out;

   sonar_tx_gen #(.CNT_W(CNT_W)) u_tx_gen (
      .clk       (clk),
      .rst       (rst),
      .enable    (tx_en),
      .tx_pulses (pulses_q),
      .tx_half   (half_q),
      .tx_out    (tx_out),
      .last      (tx_last)
   );

   always_comb begin
      state_d  = state_q;
      pulses_d = pulses_q;
      half_d   = half_q;
      blank_d  = blank_q;
      listen_d = listen_q;
      cnt_d    = cnt_q;
      hit_d    = hit_q;
      tof_d    = tof_q;
      // Sample count including a sample arriving this cycle.
      cnt_inc  = cnt_q + CNT_W'(bus.ce_pcm);

      if (bus.abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         hit_d   = 1'b0;
         tof_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start && !bus.abort) begin
                  pulses_d = bus.tx_pulses;
                  half_d   = bus.tx_half;
                  blank_d  = bus.blank_len;
                  listen_d = bus.listen_len;
                  cnt_d    = '0;
                  hit_d    = 1'b0;
                  tof_d    = '0;
                  state_d  = (bus.tx_pulses == '0) ? ST_BLANK : ST_TX;
               end
            end
            ST_TX: begin
               if (tx_last) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
               end
            end
            ST_BLANK: begin
               if (blank_q == '0) begin
                  state_d = ST_LISTEN;
                  cnt_d   = '0;
               end else if (bus.ce_pcm) begin
                  if (cnt_q == blank_q - CNT_W'(1)) begin
                     state_d = ST_LISTEN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_LISTEN: begin
               // An echo wins over a window expiring in the same cycle.
               if (bus.cmp) begin
                  state_d = ST_DONE;
                  hit_d   = 1'b1;
                  tof_d   = cnt_inc;
               end else if (bus.ce_pcm && cnt_inc >= listen_q) begin
                  state_d = ST_DONE;
                  hit_d   = 1'b0;
                  tof_d   = listen_q;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end

      tx_en = (state_d == ST_TX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pulses_q <= '0;
         half_q   <= '0;
         blank_q  <= '0;
         listen_q <= '0;
         cnt_q    <= '0;
         hit_q    <= 1'b0;
         tof_q    <= '0;
         mclear_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pulses_q <= pulses_d;
         half_q   <= half_d;
         blank_q  <= blank_d;
         listen_q <= listen_d;
         cnt_q    <= cnt_d;
         hit_q    <= hit_d;
         tof_q    <= tof_d;
         mclear_q <= (state_d == ST_BLANK);
         done_q   <= (state_d == ST_DONE);
         busy_q   <= (state_d != ST_IDLE);
      end
   end

   assign bus.tx_out = tx_out;
   assign bus.mclear = mclear_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.hit    = hit_q;
   assign bus.tof    = tof_q;
   assign bus.state  = state_q;

endmodule

// File: doc/sonar_ping_seq.md
SONAR_PING_SEQ -- requirements
Module: sonar_ping_seq

Interface
REQ-001 Parameter CNT_W, default 16: width of all config, counter and tof fields.
REQ-002 clk  input  1  rising-edge clock, same as the Wishbone clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle ping request.
REQ-005 abort  input  1  cancel the ping in progress.
REQ-006 ce_pcm  input  1  sample-rate clock enable, one clk cycle wide per PCM sample.
REQ-007 tx_pulses  input  CNT_W  number of transducer periods per burst.
REQ-008 tx_half  input  CNT_W  burst half-period, in clk cycles.
REQ-009 blank_len  input  CNT_W  blanking length, in ce_pcm samples.
REQ-010 listen_len  input  CNT_W  listen window, in ce_pcm samples.
REQ-011 cmp  input  1  latched echo-detect from the comparator/SR latch.
REQ-012 tx_out  output  1  transducer drive.
REQ-013 mclear  output  1  master clear for the detector latch and TOF timer.
REQ-014 busy  output  1  sequence in progress.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 hit  output  1  echo detected in the last completed ping.
REQ-017 tof  output  CNT_W  time of flight, in samples counted from LISTEN entry.
REQ-018 state  output  3  current state encoding.

Function
REQ-019 States SHALL be encoded IDLE=0, TX=1, BLANK=2, LISTEN=3, DONE=4; every output SHALL be registered.
REQ-020 IDLE: start=1 SHALL enter TX on the next edge, capture tx_pulses/tx_half/blank_len/listen_len into shadow registers, and clear hit and tof.
REQ-021 start while busy=1 SHALL be ignored; config input changes while busy SHALL have no effect.
REQ-022 tx_pulses=0 SHALL skip TX and enter BLANK directly from IDLE; tx_half=0 SHALL behave as tx_half=1.
REQ-023 TX: tx_out SHALL rise on the TX entry edge and toggle every tx_half clk cycles; after 2*tx_pulses half-periods it SHALL be 0 and the state SHALL be BLANK. TX lasts exactly 2*tx_pulses*tx_half cycles.
REQ-024 BLANK: mclear=1 in every BLANK cycle and 0 otherwise; the state SHALL count ce_pcm pulses and enter LISTEN on the edge of the blank_len-th pulse. blank_len=0 SHALL give exactly one BLANK cycle.
REQ-025 LISTEN: the sample counter SHALL start at 0 on entry and increment on each ce_pcm.
REQ-026 LISTEN, cmp=1 sampled: next state DONE, hit=1, tof=current counter value. cmp=1 in the first LISTEN cycle SHALL give tof=0.
REQ-027 LISTEN, counter reaches listen_len on a ce_pcm with cmp=0: next state DONE, hit=0, tof=listen_len.
REQ-028 cmp=1 and window expiry in the same cycle: hit SHALL win (hit=1, tof=counter value).
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE; hit and tof SHALL hold until the next accepted start.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with tx_out=0, mclear=0, hit=0, tof=0 and no done pulse; abort has priority over start and over all other transitions.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 rst SHALL set state=IDLE; tx_out, mclear, busy, done, hit and tof to 0; all counters and shadow registers to 0.
REQ-033 rst asserted mid-sequence SHALL return to IDLE on that edge with tx_out=0; rst has priority over abort and start.

Structure
REQ-034 State encodings and the CNT_W default SHALL live in shared package sonar_pkg.
REQ-035 Burst generation (half-period counter plus toggle counter) SHALL be one sub-module, sonar_tx_gen, with ports enable, tx_pulses, tx_half, tx_out, last.

Verification
REQ-036 start, tx_pulses=2, tx_half=3 -> tx_out pattern 111000111000 over 12 cycles, then BLANK with mclear=1.
REQ-037 blank_len=4, listen_len=10, ce_pcm every 5 cycles, cmp rises after the 6th LISTEN sample -> done pulse, hit=1, tof=6.
REQ-038 listen_len=3, cmp held 0 -> done after 3 LISTEN samples, hit=0, tof=3.
REQ-039 cmp=1 coincident with the final window sample -> hit=1, tof=listen_len; second start during LISTEN -> ignored, state unchanged.
REQ-040 abort in the 5th TX cycle -> state=0 next cycle, tx_out=0, done never asserted; rst during BLANK -> all outputs 0 on that edge.
REQ-041 tx_pulses=0, blank_len=0 -> IDLE->BLANK (1 cycle)->LISTEN; cmp=1 immediately -> tof=0, hit=1.
